if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Instruction-fetch stage of the pipelined RISC-V core: owns the PC, drives the instruction-memory address, and loads the IF/ID pipeline register whose instruction word feeds the opcode decoder.
- Consumes the decoder's halt indication and the EX-stage branch/jump redirect.
- Provides stall, flush and halt sequencing for the front end.

Parameters:
- PC_W, 9, PC / instruction-memory byte-address width; PC arithmetic wraps modulo 2^PC_W.
- INSTR_W, 32, instruction word width.
- RESET_PC, 0, PC value loaded on reset (word aligned, bits [1:0] = 0).
- NOP_INSTR, 32'h00000013, bubble word (addi x0,x0,0) inserted on flush, halt and reset.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- stall  in  1  hazard-unit stall; hold PC and IF/ID.
- redirect  in  1  EX-stage branch taken or JAL/JALR; load redirect_target.
- redirect_target  in  PC_W  new PC; bits [1:0] ignored and forced to 0.
- id_halt  in  1  decoder halt flag for the instruction currently in IF/ID.
- imem_addr  out  PC_W  instruction-memory address, equal to the PC register (combinational).
- imem_rdata  in  INSTR_W  instruction at imem_addr; asynchronous read, valid in the same cycle.
- ifid_pc  out  PC_W  PC of the instruction in IF/ID.
- ifid_instr  out  INSTR_W  instruction in IF/ID; its [6:0] is the decoder opcode.
- ifid_valid  out  1  IF/ID holds a real instruction (0 = bubble).
- halted  out  1  front end is frozen in HALTED.

Behaviour:
- Reset (reset==0 at a rising edge), regardless of state:
  - pc=RESET_PC, ifid_pc=0, ifid_instr=NOP_INSTR, ifid_valid=0, halted=0, state=RUN.
- States: RUN, HALTED. Per-edge priority is reset > redirect > HALTED > id_halt > stall > normal.
- RUN, normal (no stall, no redirect, no qualifying halt):
  - ifid_instr<=imem_rdata, ifid_pc<=pc, ifid_valid<=1, pc<=pc+4.
  - Latency: one cycle from PC to the IF/ID output.
- RUN, stall=1, redirect=0: pc, ifid_pc, ifid_instr and ifid_valid all hold.
- RUN, redirect=1, with or without stall:
  - pc<={redirect_target[PC_W-1:2],2'b00}.
  - IF/ID flushed: ifid_instr<=NOP_INSTR, ifid_valid<=0, ifid_pc<=0.
  - The next cycle fetches from the target.
- RUN, id_halt=1, ifid_valid=1, redirect=0:
  - Transition to HALTED; the stall value is ignored.
  - pc holds; IF/ID flushed to a bubble; halted<=1.
- id_halt while ifid_valid=0 is ignored.
- id_halt together with redirect: redirect wins and the halt is discarded (wrong-path instruction); state stays RUN.
- HALTED:
  - pc, ifid_* and halted hold; stall and id_halt are ignored.
  - Only reset exits HALTED.
  - A redirect in HALTED is ignored, since every older instruction has already left EX by then.
- Wrap-around: pc=2^PC_W-4 with a normal advance -> pc=0.
- imem_addr always equals pc, including during stall and HALTED.
- Reset mid-operation (e.g. during a stall or while HALTED) takes effect at the same edge, with the full reset values above.

Optional Feature:
- Macro: IF_FETCH_PERF_EN.
- When defined, two extra outputs are added:
  - fetch_cnt (32 bits): increments on every edge where IF/ID loads a real instruction (ifid_valid<=1).
  - flush_cnt (32 bits): increments on every accepted redirect.
- Both counters wrap modulo 2^32, clear on reset, and hold in HALTED.
- When undefined, neither the ports nor the registers exist, and the behaviour is otherwise identical.

Test Plan:
- Reset then 4 cycles free-running, imem returning addr-based words -> imem_addr 0,4,8,12; ifid_pc 0,4,8 with ifid_valid=1 from the 2nd edge; all outputs at reset values while reset=0.
- pc=8, stall held 3 cycles -> pc stays 8, ifid_instr/ifid_pc unchanged, imem_addr=8; fetch resumes at 12 after stall drops.
- redirect=1, target=9'h0A6, with stall=1 in the same cycle -> next pc=0x0A4, ifid_instr=32'h00000013, ifid_valid=0; following edge ifid_pc=0x0A4.
- ifid_instr opcode 7'b1000000 with id_halt=1, ifid_valid=1 -> halted=1, pc frozen, ifid_valid=0 for 10 cycles despite redirect pulses; reset=0 -> RUN at RESET_PC.
- id_halt=1 and redirect=1 in the same cycle (target 0x040) -> halted stays 0, pc=0x040.
- pc=0x1FC, normal advance -> pc=0x000; with IF_FETCH_PERF_EN, fetch_cnt and flush_cnt match the counted loads and redirects across all scenarios above.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC, drives imem, loads IF/ID one cycle after the PC; stall holds PC and IF/ID.
// Optional fetch/flush performance counters are enabled by defining IF_FETCH_PERF_EN.
module if_fetch_unit #(
  parameter int                 PC_W      = 9,
  parameter int                 INSTR_W   = 32,
  parameter logic [PC_W-1:0]    RESET_PC  = '0,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_target,
  input  logic               id_halt,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [PC_W-1:0]    ifid_pc,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic               ifid_valid,
  output logic               halted
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0]        fetch_cnt,
  output logic [31:0]        flush_cnt
`endif
);

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  state_t            state;
  state_t            next_state;
  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   target_pc;
  logic              run;
  logic              take_redirect;
  logic              take_halt;
  logic              do_fetch;
  logic              unused_target_lsb;

  assign target_pc         = {redirect_target[PC_W-1:2], 2'b00};
  assign unused_target_lsb = ^redirect_target[1:0];

  // A halt only counts for a real instruction, and a redirect marks it wrong-path.
  assign run           = (state == RUN);
  assign take_redirect = run && redirect;
  assign take_halt     = run && !redirect && id_halt && ifid_valid;
  assign do_fetch      = run && !redirect && !take_halt && !stall;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (take_halt) begin
      next_state = HALTED;
    end
  end

  always_comb begin
    halted    = (state == HALTED);
    imem_addr = pc;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc         <= RESET_PC;
      ifid_pc    <= '0;
      ifid_instr <= NOP_INSTR;
      ifid_valid <= 1'b0;
    end else if (take_redirect || take_halt) begin
      if (take_redirect) begin
        pc <= target_pc;
      end
      ifid_pc    <= '0;
      ifid_instr <= NOP_INSTR;
      ifid_valid <= 1'b0;
    end else if (do_fetch) begin
      pc         <= pc + PC_W'(4);
      ifid_pc    <= pc;
      ifid_instr <= imem_rdata;
      ifid_valid <= 1'b1;
    end
  end

`ifdef IF_FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (do_fetch) begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end
      if (take_redirect) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus random stimulus against a behavioural front-end model.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [8:0]  redirect_target;
  logic        id_halt;
  logic [8:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic [8:0]  ifid_pc;
  logic [31:0] ifid_instr;
  logic        ifid_valid;
  logic        halted;
`ifdef IF_FETCH_PERF_EN
  logic [31:0] fetch_cnt;
  logic [31:0] flush_cnt;
`endif

  logic        halt_armed = 1'b0;
  logic [8:0]  halt_addr  = '0;

  int n_vec  = 0;
  int n_fail = 0;
  logic checking = 1'b0;

  // Behavioural model of the architected front-end state
  logic [8:0]  m_pc;
  logic [8:0]  m_ifid_pc;
  logic [31:0] m_instr;
  logic        m_valid;
  logic        m_halted;
  logic [31:0] m_fetch;
  logic [31:0] m_flush;

  always #5 clk = ~clk;

  assign imem_rdata = {7'h2B, imem_addr, 9'h155,
                       (halt_armed && imem_addr == halt_addr) ? 7'h40 : 7'h33};

  if_fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .id_halt         (id_halt),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .ifid_pc         (ifid_pc),
    .ifid_instr      (ifid_instr),
    .ifid_valid      (ifid_valid),
    .halted          (halted)
`ifdef IF_FETCH_PERF_EN
    ,
    .fetch_cnt       (fetch_cnt),
    .flush_cnt       (flush_cnt)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [8:0] a, input logic armed,
                                           input logic [8:0] ha);
    return {7'h2B, a, 9'h155, (armed && a == ha) ? 7'h40 : 7'h33};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic rs, input logic st, input logic rd,
                            input logic [8:0] tg, input logic ih);
    if (!rs) begin
      m_pc = 9'h000; m_ifid_pc = 9'h000; m_instr = 32'h13; m_valid = 1'b0;
      m_halted = 1'b0; m_fetch = 0; m_flush = 0;
    end else if (!m_halted) begin
      if (rd) begin
        m_pc = tg & 9'h1FC;
        m_ifid_pc = 9'h000; m_instr = 32'h13; m_valid = 1'b0;
        m_flush = m_flush + 1;
      end else if (ih && m_valid) begin
        m_ifid_pc = 9'h000; m_instr = 32'h13; m_valid = 1'b0;
        m_halted = 1'b1;
      end else if (!st) begin
        m_instr   = mem_word(m_pc, halt_armed, halt_addr);
        m_ifid_pc = m_pc;
        m_valid   = 1'b1;
        m_pc      = (m_pc + 9'd4) % 512;
        m_fetch   = m_fetch + 1;
      end
    end
  endtask

  task automatic step(input logic rs, input logic st, input logic rd,
                      input logic [8:0] tg, input logic ih);
    reset = rs; stall = st; redirect = rd; redirect_target = tg; id_halt = ih;
    @(posedge clk);
    model_edge(rs, st, rd, tg, ih);
    #2;
  endtask

  always @(posedge clk) begin
    if (checking) begin
      #1;
      chk("imem_addr",  {23'd0, imem_addr}, {23'd0, m_pc});
      chk("ifid_pc",    {23'd0, ifid_pc},   {23'd0, m_ifid_pc});
      chk("ifid_instr", ifid_instr,         m_instr);
      chk("ifid_valid", {31'd0, ifid_valid}, {31'd0, m_valid});
      chk("halted",     {31'd0, halted},     {31'd0, m_halted});
`ifdef IF_FETCH_PERF_EN
      chk("fetch_cnt",  fetch_cnt, m_fetch);
      chk("flush_cnt",  flush_cnt, m_flush);
`endif
    end
  end

  initial begin
    reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_target = '0; id_halt = 1'b0;
    checking = 1'b1;

    // Reset held: outputs at reset values
    step(0, 0, 0, 9'h0, 0);
    step(0, 1, 1, 9'h1F0, 1);
    chk("rst_addr",  {23'd0, imem_addr}, 32'd0);
    chk("rst_valid", {31'd0, ifid_valid}, 32'd0);
    chk("rst_instr", ifid_instr, 32'h00000013);
    chk("rst_halted", {31'd0, halted}, 32'd0);

    // Free run to pc=8, then stall 3 cycles
    step(1, 0, 0, 9'h0, 0);
    chk("run1_ifid_pc", {23'd0, ifid_pc}, 32'd0);
    chk("run1_valid", {31'd0, ifid_valid}, 32'd1);
    step(1, 0, 0, 9'h0, 0);
    chk("run2_addr", {23'd0, imem_addr}, 32'd8);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 9'h0, 0);
    chk("stall_addr", {23'd0, imem_addr}, 32'd8);
    chk("stall_ifid_pc", {23'd0, ifid_pc}, 32'd4);
    step(1, 0, 0, 9'h0, 0);
    chk("resume_addr", {23'd0, imem_addr}, 32'd12);
    chk("resume_ifid_pc", {23'd0, ifid_pc}, 32'd8);

    // Redirect with stall, target 0x0A6
    step(1, 1, 1, 9'h0A6, 0);
    chk("redir_addr", {23'd0, imem_addr}, 32'h0A4);
    chk("redir_instr", ifid_instr, 32'h00000013);
    chk("redir_valid", {31'd0, ifid_valid}, 32'd0);
    step(1, 0, 0, 9'h0, 0);
    chk("redir_ifid_pc", {23'd0, ifid_pc}, 32'h0A4);

    // Halt opcode at 0x0A8
    halt_armed = 1'b1; halt_addr = 9'h0A8;
    step(1, 0, 0, 9'h0, 0);
    chk("halt_opcode", {25'd0, ifid_instr[6:0]}, 32'h40);
    step(1, 1, 0, 9'h0, (m_instr[6:0] == 7'h40));
    chk("halt_enter", {31'd0, halted}, 32'd1);
    for (int i = 0; i < 10; i++)
      step(1, $urandom_range(0, 1), i[0], 9'($urandom), $urandom_range(0, 1));
    chk("halt_pc", {23'd0, imem_addr}, 32'h0AC);
    chk("halt_valid", {31'd0, ifid_valid}, 32'd0);
    step(0, 0, 0, 9'h0, 0);
    halt_armed = 1'b0;
    chk("halt_exit", {31'd0, halted}, 32'd0);
    chk("halt_exit_pc", {23'd0, imem_addr}, 32'd0);
`ifdef IF_FETCH_PERF_EN
    chk("perf_rst", fetch_cnt | flush_cnt, 32'd0);
`endif

    // id_halt and redirect together: redirect wins
    step(1, 0, 0, 9'h0, 0);
    step(1, 0, 1, 9'h040, 1);
    chk("hr_halted", {31'd0, halted}, 32'd0);
    chk("hr_pc", {23'd0, imem_addr}, 32'h040);
`ifdef IF_FETCH_PERF_EN
    chk("perf_counts", {fetch_cnt[15:0], flush_cnt[15:0]}, {16'd1, 16'd1});
`endif

    // Wrap-around from 0x1FC
    step(1, 0, 1, 9'h1FF, 0);
    step(1, 0, 0, 9'h0, 0);
    chk("wrap_pc", {23'd0, imem_addr}, 32'd0);
    chk("wrap_ifid_pc", {23'd0, ifid_pc}, 32'h1FC);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1,
           ($urandom_range(0, 99) < 30),
           ($urandom_range(0, 99) < 10),
           9'($urandom),
           ($urandom_range(0, 99) < 4));
    end

    checking = 1'b0;
    #20;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
